gcn_readout_sequencer: RTL and testbench
========================================

// Module: gcn_readout_sequencer
// PURPOSE
//  Top-level sequencer for the Combination datapath. On a go pulse it issues a 1-cycle start,
//  waits for done_comb to rise, then walks the FM_WM_ADJ memory rows through read_argmax,
//  computes the per-node argmax over WEIGHT_COLS dot products and publishes max_addi_answer.
//  It has a watchdog so a hung Combination run cannot stall the sequencer forever.
// PARAMETERS
//  NUM_OF_NODES      6      rows (nodes) to read back
//  WEIGHT_COLS       3      dot products per row
//  DOT_PROD_WIDTH    16     width of each dot product
//  COO_BW            $clog2(NUM_OF_NODES)  row-address width
//  MAX_ADDRESS_WIDTH $clog2(WEIGHT_COLS)   argmax index width (2 at defaults)
//  READ_LATENCY      0      cycles from read_argmax to valid fm_wm_adj_row_in (0..3)
//  SIGNED_CMP        0      1: compare dot products as two's complement, 0: unsigned
//  TIMEOUT_CYCLES    4096   maximum WAIT_COMB cycles before abort
// PORTS
//  clk               in   1   clock, rising edge
//  reset             in   1   asynchronous, active-high reset
//  go                in   1   1-cycle request to run one full layer
//  done_comb         in   1   Combination completion level
//  fm_wm_adj_row_in  in   DOT_PROD_WIDTH x WEIGHT_COLS  row data from FM_WM_ADJ memory
//  start             out  1   1-cycle start pulse to Combination
//  read_argmax       out  COO_BW  row address into FM_WM_ADJ memory
//  max_addi_answer   out  MAX_ADDRESS_WIDTH x NUM_OF_NODES  per-node argmax
//  busy              out  1   high from KICK through CAPTURE
//  done              out  1   high in DONE, held
//  error             out  1   watchdog abort flag, valid while done=1
// BEHAVIOUR
//  Reset: state=IDLE, start=0, read_argmax=0, max_addi_answer all 0, busy=0, done=0, error=0,
//   row counter, wait counter and watchdog cleared. Asserting reset mid-run aborts at once.
//  FSM states: IDLE, KICK, WAIT_COMB, READ, DONE.
//  IDLE: go=1 -> KICK. Clear max_addi_answer and error.
//  DONE: go=1 -> KICK. Clear max_addi_answer and error. Otherwise done stays high.
//  KICK: start=1 for exactly this cycle. row=0. Always -> WAIT_COMB.
//  WAIT_COMB: advance only on a done_comb rising edge (done_comb=1 with a registered
//   previous value of 0). The registered previous value is 0 out of reset. A done_comb
//   left high from an earlier run does not satisfy WAIT_COMB. Rising edge -> READ.
//   The watchdog counts cycles in this state. At TIMEOUT_CYCLES -> DONE with error=1 and
//   max_addi_answer left at 0.
//  READ: drive read_argmax=row. A wait counter runs 0..READ_LATENCY. When the counter equals
//   READ_LATENCY, sample fm_wm_adj_row_in in that same cycle and compute the argmax.
//  Argmax: the index of the largest element, using the comparison selected by SIGNED_CMP.
//   Ties resolve to the lowest index. Write the result to max_addi_answer[row].
//   If row==NUM_OF_NODES-1 -> DONE, else row++ and restart the wait counter.
//  Each row costs READ_LATENCY+1 cycles. Readout takes NUM_OF_NODES*(READ_LATENCY+1) cycles.
//  done asserts the cycle after the last capture.
//  read_argmax holds its last value outside READ. The row counter never wraps: the final row
//   exits to DONE.
//  go while busy=1 is ignored and not queued. go in the same cycle as the timeout has no
//   effect on that transition.
//  done_comb that rises during READ or DONE is ignored.
//  All outputs are registered except start and busy, which are decoded from state.
// TESTING
//  1 Reset then go, done_comb rising 10 cycles after start, rows {5,9,2},{7,7,1},{0,0,0},
//    {1,2,3},{3,2,1},{4,8,8} -> start is one pulse; answers 1,0,0,2,0,1; done after 6 reads.
//  2 SIGNED_CMP=1, row {16'hFFFF,16'h0001,16'h8000} -> answer 1.
//    SIGNED_CMP=0 with the same row -> answer 0.
//  3 READ_LATENCY=2 -> read_argmax steps every 3 cycles and the data is sampled on the 3rd
//    cycle only; garbage on cycles 1-2 does not affect the answers.
//  4 done_comb held high before go -> the sequencer waits for a fall then rise.
//    Never rising, with TIMEOUT_CYCLES=16 -> DONE on cycle 16 with error=1 and answers 0.
//  5 go pulsed in WAIT_COMB and in READ -> no second start and no state change.
//    go in DONE -> answers clear and a new start pulse follows.
//  6 reset asserted mid-READ (row 3) -> all outputs return to reset values immediately.
//    A following go runs a full clean layer.

Source files
------------

// File: rtl/gcn_readout_sequencer.sv
// Readout sequencer: kicks Combination, waits for done_comb to rise, then
// walks FM_WM_ADJ rows and publishes a per-node argmax.
// Ports: clk, reset (async, active-high), go, done_comb, fm_wm_adj_row_in ->
//   start, read_argmax, max_addi_answer, busy, done, error.
module gcn_readout_sequencer #(
  parameter int NUM_OF_NODES      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int COO_BW            = $clog2(NUM_OF_NODES),
  parameter int MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS),
  parameter int READ_LATENCY      = 0,
  parameter bit SIGNED_CMP        = 1'b0,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic done_comb,
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_adj_row_in,
  output logic start,
  output logic [COO_BW-1:0] read_argmax,
  output logic [NUM_OF_NODES-1:0][MAX_ADDRESS_WIDTH-1:0] max_addi_answer,
  output logic busy,
  output logic done,
  output logic error
);

  localparam int WC_W =
    (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, KICK, WAIT_COMB, READ, DONE
  } state_t;

  state_t state_q, state_d;
  logic [COO_BW-1:0] row_q, row_d;
  logic [COO_BW-1:0] ra_q, ra_d;
  logic [WC_W-1:0] wc_q, wc_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [NUM_OF_NODES-1:0][MAX_ADDRESS_WIDTH-1:0] ans_q, ans_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic comb_prev_q;
  logic comb_rise;

  logic [MAX_ADDRESS_WIDTH-1:0] best_idx;
  logic [DOT_PROD_WIDTH-1:0] best_val;

  function automatic logic gt(
    input logic [DOT_PROD_WIDTH-1:0] a,
    input logic [DOT_PROD_WIDTH-1:0] b
  );
    if (SIGNED_CMP) return $signed(a) > $signed(b);
    else return a > b;
  endfunction

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = fm_wm_adj_row_in[0];
    for (int i = 1; i < WEIGHT_COLS; i++) begin
      if (gt(fm_wm_adj_row_in[i], best_val)) begin
        best_val = fm_wm_adj_row_in[i];
        best_idx = MAX_ADDRESS_WIDTH'(i);
      end
    end
  end

  // A level left high from a previous run must not count.
  assign comb_rise = done_comb & ~comb_prev_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ra_d    = ra_q;
    wc_d    = wc_q;
    wd_d    = wd_q;
    ans_d   = ans_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = KICK;
          ans_d   = '0;
          err_d   = 1'b0;
        end
      end
      KICK: begin
        row_d   = '0;
        wc_d    = '0;
        wd_d    = '0;
        state_d = WAIT_COMB;
      end
      WAIT_COMB: begin
        if (comb_rise) begin
          state_d = READ;
          ra_d    = row_q;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      READ: begin
        if (wc_q == WC_W'(READ_LATENCY)) begin
          ans_d[row_q] = best_idx;
          wc_d = '0;
          if (row_q == COO_BW'(NUM_OF_NODES - 1)) begin
            state_d = DONE;
          end else begin
            row_d = row_q + COO_BW'(1);
            ra_d  = row_q + COO_BW'(1);
          end
        end else begin
          wc_d = wc_q + WC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      ra_q        <= '0;
      wc_q        <= '0;
      wd_q        <= '0;
      ans_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      comb_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      ra_q        <= ra_d;
      wc_q        <= wc_d;
      wd_q        <= wd_d;
      ans_q       <= ans_d;
      done_q      <= done_d;
      err_q       <= err_d;
      comb_prev_q <= done_comb;
    end
  end

  assign start           = (state_q == KICK);
  assign busy            = (state_q == KICK) ||
                           (state_q == WAIT_COMB) ||
                           (state_q == READ);
  assign read_argmax     = ra_q;
  assign max_addi_answer = ans_q;
  assign done            = done_q;
  assign error           = err_q;

endmodule

// File: tb/tb_gcn_readout_sequencer.sv
// Directed bench for gcn_readout_sequencer: three instances
// (unsigned/lat0, signed/lat0, unsigned/lat2) share go, done_comb and reset.
module tb_gcn_readout_sequencer;

  logic clk = 1'b0;
  logic reset, go, done_comb;
  always #5 clk = ~clk;

  logic [2:0][15:0] fm_a, fm_b, fm_c;
  logic start_a, start_b, start_c;
  logic [2:0] ra_a, ra_b, ra_c;
  logic [5:0][1:0] ans_a, ans_b, ans_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic err_a, err_b, err_c;

  gcn_readout_sequencer #(.TIMEOUT_CYCLES(16)) u_a (
    .clk(clk), .reset(reset), .go(go), .done_comb(done_comb),
    .fm_wm_adj_row_in(fm_a), .start(start_a), .read_argmax(ra_a),
    .max_addi_answer(ans_a), .busy(busy_a), .done(done_a),
    .error(err_a));

  gcn_readout_sequencer #(.TIMEOUT_CYCLES(16), .SIGNED_CMP(1'b1)) u_b (
    .clk(clk), .reset(reset), .go(go), .done_comb(done_comb),
    .fm_wm_adj_row_in(fm_b), .start(start_b), .read_argmax(ra_b),
    .max_addi_answer(ans_b), .busy(busy_b), .done(done_b),
    .error(err_b));

  gcn_readout_sequencer #(.TIMEOUT_CYCLES(16), .READ_LATENCY(2)) u_c (
    .clk(clk), .reset(reset), .go(go), .done_comb(done_comb),
    .fm_wm_adj_row_in(fm_c), .start(start_c), .read_argmax(ra_c),
    .max_addi_answer(ans_c), .busy(busy_c), .done(done_c),
    .error(err_c));

  logic [15:0] mem [6][3];
  logic [2:0] c_d1, c_d2;

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      fm_a[j] = mem[ra_a][j];
      fm_b[j] = mem[ra_b][j];
    end
  end

  // Two-cycle memory: data is only valid once the address has been
  // stable for two clocks; before that the bus carries a decoy whose
  // argmax is 2.
  always_ff @(posedge clk) begin
    c_d1 <= ra_c;
    c_d2 <= c_d1;
  end
  always_comb begin
    if (c_d1 == ra_c && c_d2 == ra_c) begin
      for (int j = 0; j < 3; j++) fm_c[j] = mem[ra_c][j];
    end else begin
      fm_c[0] = 16'h0000;
      fm_c[1] = 16'h0000;
      fm_c[2] = 16'hFFFF;
    end
  end

  int errors = 0;
  int checks = 0;
  int starts_a = 0;

  always @(negedge clk) if (start_a) starts_a++;

  logic [5:0][1:0] exp1;
  initial begin
    exp1[0] = 2'd1; exp1[1] = 2'd0; exp1[2] = 2'd0;
    exp1[3] = 2'd2; exp1[4] = 2'd0; exp1[5] = 2'd1;
  end

  task automatic load_mem1;
    mem[0][0] = 5; mem[0][1] = 9; mem[0][2] = 2;
    mem[1][0] = 7; mem[1][1] = 7; mem[1][2] = 1;
    mem[2][0] = 0; mem[2][1] = 0; mem[2][2] = 0;
    mem[3][0] = 1; mem[3][1] = 2; mem[3][2] = 3;
    mem[4][0] = 3; mem[4][1] = 2; mem[4][2] = 1;
    mem[5][0] = 4; mem[5][1] = 8; mem[5][2] = 8;
  endtask

  // Pulse go, wait gap cycles after KICK, then raise done_comb.
  task automatic run_layer(input int gap);
    done_comb = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (gap) @(negedge clk);
    done_comb = 1'b1;
  endtask

  task automatic wait_all_done(output bit ok);
    for (int i = 0; i < 80; i++) begin
      if (done_a && done_b && done_c) break;
      @(negedge clk);
    end
    ok = done_a && done_b && done_c;
  endtask

  task automatic test_reset;
    reset = 1'b1; go = 1'b0; done_comb = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({start_a, busy_a, done_a, err_a, ra_a, ans_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
        {start_a, busy_a, done_a, err_a, ra_a, ans_a});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    int n0;
    load_mem1();
    n0 = starts_a;
    done_comb = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (start_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL kick_start got %b%b want 11", start_a, busy_a);
    end
    repeat (10) @(negedge clk);
    done_comb = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ra_a !== 3'(k) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL read_row%0d got ra=%0d busy=%b want ra=%0d busy=1",
          k, ra_a, busy_a, k);
      end
      @(negedge clk);
    end
    checks++;
    if (done_a !== 1'b1 || err_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL done_after_6 got d=%b e=%b b=%b want 1 0 0",
        done_a, err_a, busy_a);
    end
    checks++;
    if (ans_a !== exp1) begin
      errors++;
      $display("FAIL basic_answers got %h want %h", ans_a, exp1);
    end
    checks++;
    if (starts_a - n0 != 1) begin
      errors++;
      $display("FAIL start_pulses got %0d want 1", starts_a - n0);
    end
    wait_all_done(ok);
    checks++;
    if (!ok || ans_b !== exp1) begin
      errors++;
      $display("FAIL basic_signed got %h ok=%b want %h", ans_b, ok, exp1);
    end
    done_comb = 1'b0;
  endtask

  task automatic test_signed;
    bit ok;
    load_mem1();
    mem[0][0] = 16'hFFFF; mem[0][1] = 16'h0001; mem[0][2] = 16'h8000;
    mem[1][0] = 16'h8000; mem[1][1] = 16'h7FFF; mem[1][2] = 16'h0000;
    run_layer(3);
    wait_all_done(ok);
    checks++;
    if (!ok || ans_a[0] !== 2'd0 || ans_a[1] !== 2'd0) begin
      errors++;
      $display("FAIL unsigned_cmp got %0d,%0d want 0,0",
        ans_a[0], ans_a[1]);
    end
    checks++;
    if (!ok || ans_b[0] !== 2'd1 || ans_b[1] !== 2'd1) begin
      errors++;
      $display("FAIL signed_cmp got %0d,%0d want 1,1",
        ans_b[0], ans_b[1]);
    end
    done_comb = 1'b0;
  endtask

  task automatic test_latency;
    bit ok;
    load_mem1();
    run_layer(4);
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      checks++;
      if (ra_c !== 3'(k / 3) || busy_c !== 1'b1) begin
        errors++;
        $display("FAIL lat2_step%0d got ra=%0d busy=%b want ra=%0d",
          k, ra_c, busy_c, k / 3);
      end
      @(negedge clk);
    end
    checks++;
    if (done_c !== 1'b1) begin
      errors++;
      $display("FAIL lat2_done got %b want 1", done_c);
    end
    wait_all_done(ok);
    checks++;
    if (!ok || ans_c !== exp1) begin
      errors++;
      $display("FAIL lat2_answers got %h want %h", ans_c, exp1);
    end
    done_comb = 1'b0;
  endtask

  task automatic test_comb_edge;
    bit ok;
    load_mem1();
    done_comb = 1'b1;
    repeat (2) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || busy_c !== 1'b1) begin
      errors++;
      $display("FAIL held_high got busy=%b done=%b want 1 0",
        busy_a, done_a);
    end
    done_comb = 1'b0;
    @(negedge clk);
    done_comb = 1'b1;
    wait_all_done(ok);
    checks++;
    if (!ok || err_a !== 1'b0 || ans_a !== exp1) begin
      errors++;
      $display("FAIL fall_rise got %h err=%b want %h err=0",
        ans_a, err_a, exp1);
    end
    done_comb = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL wd_early got done=%b want 0", done_a);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1 || err_a !== 1'b1 || ans_a !== '0) begin
      errors++;
      $display("FAIL wd_abort got d=%b e=%b ans=%h want 1 1 0",
        done_a, err_a, ans_a);
    end
    checks++;
    if (err_c !== 1'b1 || ans_c !== '0) begin
      errors++;
      $display("FAIL wd_abort_c got e=%b ans=%h want 1 0", err_c, ans_c);
    end
  endtask

  task automatic test_go_ignored;
    bit ok;
    int n0;
    load_mem1();
    n0 = starts_a;
    done_comb = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    checks++;
    if (starts_a - n0 != 1 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL go_in_wait got starts=%0d busy=%b want 1 1",
        starts_a - n0, busy_a);
    end
    done_comb = 1'b1;
    repeat (3) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (ra_a !== 3'd3 || busy_a !== 1'b1 || start_a !== 1'b0) begin
      errors++;
      $display("FAIL go_in_read got ra=%0d busy=%b start=%b want 3 1 0",
        ra_a, busy_a, start_a);
    end
    wait_all_done(ok);
    checks++;
    if (!ok || starts_a - n0 != 1 || ans_a !== exp1) begin
      errors++;
      $display("FAIL go_ignored_end got starts=%0d ans=%h want 1 %h",
        starts_a - n0, ans_a, exp1);
    end
    done_comb = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (start_a !== 1'b1 || ans_a !== '0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL go_in_done got start=%b ans=%h done=%b want 1 0 0",
        start_a, ans_a, done_a);
    end
    repeat (3) @(negedge clk);
    done_comb = 1'b1;
    wait_all_done(ok);
    checks++;
    if (!ok || ans_a !== exp1 || starts_a - n0 != 2) begin
      errors++;
      $display("FAIL rerun got %h starts=%0d want %h 2",
        ans_a, starts_a - n0, exp1);
    end
    done_comb = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    bit ok;
    load_mem1();
    run_layer(4);
    repeat (4) @(negedge clk);
    checks++;
    if (ra_a !== 3'd3) begin
      errors++;
      $display("FAIL mid_read_row got %0d want 3", ra_a);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({start_a, busy_a, done_a, err_a, ra_a, ans_a} !== '0 ||
        ans_c !== '0 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %h want 0",
        {start_a, busy_a, done_a, err_a, ra_a, ans_a});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_layer(5);
    wait_all_done(ok);
    checks++;
    if (!ok || ans_a !== exp1 || ans_c !== exp1 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got a=%h c=%h want %h",
        ans_a, ans_c, exp1);
    end
    done_comb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_latency();
    test_comb_edge();
    test_go_ignored();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
